add_seq_ctrl: RTL



---
 rtl/add_seq_ctrl_if.sv | 39 +++
 rtl/add_seq_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/add_seq_ctrl_if.sv
// add_seq_ctrl_if: request/result bundle for the byte-serial adder.
// Optional macro ADD_SEQ_CTRL_SUB_EN adds the in_sub request bit.
interface add_seq_ctrl_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_ci;
`ifdef ADD_SEQ_CTRL_SUB_EN
  logic         in_sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_x;
  logic         out_co;
  logic         busy;

  // Requester/consumer side
  modport master (
`ifdef ADD_SEQ_CTRL_SUB_EN
    output in_sub,
`endif
    output in_valid, in_a, in_b, in_ci, out_ready,
    input  in_ready, out_valid, out_x, out_co, busy
  );

  // Adder sequencer side
  modport slave (
`ifdef ADD_SEQ_CTRL_SUB_EN
    input  in_sub,
`endif
    input  in_valid, in_a, in_b, in_ci, out_ready,
    output in_ready, out_valid, out_x, out_co, busy
  );
endinterface

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: runs one 8-bit adder slice over NBYTES operand bytes,
// LSB first, one byte per clock, chaining the carry through r_carry.
// Optional macro ADD_SEQ_CTRL_SUB_EN: adds in_sub; when set, B is inverted
// byte by byte and the initial carry is forced to 1 (A - B, co = no borrow).
module add_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  add_seq_ctrl_if.slave bus
);
  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic           r_carry;
  logic [IDXW-1:0] r_idx;
  logic [W-1:0]   r_x;
  logic           r_co;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           r_busy;
`ifdef ADD_SEQ_CTRL_SUB_EN
  logic           r_sub;
`endif

  logic [7:0]     w_a_byte;
  logic [7:0]     w_b_byte;
  logic [8:0]     w_sum;
  logic [IDXW+2:0] w_bit_ofs;
  logic           w_accept;
  logic           w_last;

  // Byte offset of the current slice (idx * 8).
  assign w_bit_ofs = {r_idx, 3'b000};
  assign w_a_byte  = r_a[w_bit_ofs +: 8];
`ifdef ADD_SEQ_CTRL_SUB_EN
  assign w_b_byte  = r_sub ? ~r_b[w_bit_ofs +: 8] : r_b[w_bit_ofs +: 8];
`else
  assign w_b_byte  = r_b[w_bit_ofs +: 8];
`endif
  assign w_sum     = {1'b0, w_a_byte} + {1'b0, w_b_byte} + {8'd0, r_carry};
  assign w_accept  = (r_state == S_IDLE) && bus.in_valid;
  assign w_last    = (r_idx == LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: accept in IDLE, walk bytes in RUN, wait for consumer in DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Handshake/status outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  // Datapath: capture operands on accept, then one slice add per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_x     <= '0;
      r_co    <= 1'b0;
`ifdef ADD_SEQ_CTRL_SUB_EN
      r_sub   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a   <= bus.in_a;
            r_b   <= bus.in_b;
            r_idx <= '0;
`ifdef ADD_SEQ_CTRL_SUB_EN
            r_sub   <= bus.in_sub;
            r_carry <= bus.in_sub ? 1'b1 : bus.in_ci;
`else
            r_carry <= bus.in_ci;
`endif
          end else begin
            r_idx <= r_idx;
          end
        end
        S_RUN: begin
          r_x[w_bit_ofs +: 8] <= w_sum[7:0];
          r_carry             <= w_sum[8];
          if (w_last) begin
            r_co  <= w_sum[8];
            r_idx <= '0;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        S_DONE: begin
          r_idx <= r_idx;
        end
        default: begin
          r_idx <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_x     = r_x;
  assign bus.out_co    = r_co;
  assign bus.busy      = r_busy;
endmodule
